control_sequencer: RTL and testbench

- Instruction-phase controller for the accumulator CPU. Steps through an 8-phase cycle for each instruction.
- Drives the select line of the address multiplexor (sel=1 places the instruction address on the memory address bus, sel=0 places the operand address).
- Also drives memory read/write, IR/PC/AC load, PC increment, data-bus enable and halt strobes, decoded from the current phase, the opcode held in the IR, and the accumulator zero flag.
- Sits between the instruction register/ALU flags and the address mux, PC, IR, AC and memory.

---
 rtl/control_sequencer.sv | 156 +++++++++++++++
 tb/tb_control_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: eight-phase instruction controller for the accumulator CPU.
// A 3-bit phase counter plus a sticky halted flag form the whole state; every
// control strobe is decoded combinationally from that state, the IR opcode and
// the accumulator zero flag, so an asynchronous reset clears the strobes at once.
module control_sequencer #(
    parameter int OPCODE_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    output logic                    sel,
    output logic                    rd,
    output logic                    wr,
    output logic                    ld_ir,
    output logic                    ld_ac,
    output logic                    ld_pc,
    output logic                    inc_pc,
    output logic                    data_e,
    output logic                    halt,
    output logic [2:0]              phase
);

    // Fixed opcode encoding of the instruction set.
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

    // Instruction phases; the encoding is the debug phase number.
    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;

    // Opcode class decodes shared by several phases.
    logic is_hlt, is_skz, is_sto, is_jmp, is_aluop;

    // Classify the opcode held in the IR.
    always_comb begin
        is_hlt   = (opcode == OP_HLT);
        is_skz   = (opcode == OP_SKZ);
        is_sto   = (opcode == OP_STO);
        is_jmp   = (opcode == OP_JMP);
        is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
    end

    // Next-state logic: walk the fixed phase ring, or park in OP_ADDR once halted.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            unique case (phase_q)
                PH_INST_ADDR:  phase_d = PH_INST_FETCH;
                PH_INST_FETCH: phase_d = PH_INST_LOAD;
                PH_INST_LOAD:  phase_d = PH_IDLE;
                PH_IDLE:       phase_d = PH_OP_ADDR;
                PH_OP_ADDR: begin
                    // A HLT freezes the phase at OP_ADDR; only reset leaves it.
                    if (is_hlt) halted_d = 1'b1;
                    else        phase_d  = PH_OP_FETCH;
                end
                PH_OP_FETCH:   phase_d = PH_ALU_OP;
                PH_ALU_OP:     phase_d = PH_STORE;
                PH_STORE:      phase_d = PH_INST_ADDR;
                default:       phase_d = PH_INST_ADDR;
            endcase
        end
    end

    // State register with asynchronous clear to INST_ADDR, not halted.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so all state updates see pre-edge values.
        if (!rst_n) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Output decode from registered state, opcode and zero flag.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            // Halted: only the halt indicator stays up.
            halt = 1'b1;
        end else begin
            unique case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                PH_OP_FETCH: begin
                    rd = is_aluop;
                end
                PH_ALU_OP: begin
                    rd     = is_aluop;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                PH_STORE: begin
                    rd     = is_aluop;
                    ld_ac  = is_aluop;
                    inc_pc = is_jmp;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: begin
                    sel = 1'b1;
                end
            endcase
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each task runs one scenario and
// compares the strobe bundle and phase against hand-derived tables.
module tb_control_sequencer;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [2:0] phase;

    int vectors     = 0;
    int miscompares = 0;

    // Bundle order: {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
    logic [8:0] outs;
    assign outs = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};

    localparam logic [8:0] E_RST  = 9'b100000000;
    localparam logic [8:0] E_IA   = 9'b100000000;
    localparam logic [8:0] E_IF   = 9'b110000000;
    localparam logic [8:0] E_IL   = 9'b110100000;
    localparam logic [8:0] E_ID   = 9'b110100000;
    localparam logic [8:0] E_OA   = 9'b000000100;
    localparam logic [8:0] E_HLT4 = 9'b000000101;
    localparam logic [8:0] E_HALT = 9'b000000001;
    localparam logic [8:0] E_NONE = 9'b000000000;

    control_sequencer #(.OPCODE_WIDTH(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        opcode = 3'd2;
        zero   = 1'b0;
        #2;
        for (int c = 0; c < 3; c++) begin
            step();
            opcode = 3'(c * 3 + 1);
            zero   = ~zero;
            #1;
            vectors++;
            if (outs !== E_RST || phase !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_hold cyc%0d: got outs=%b phase=%0d, want outs=%b phase=0",
                         c, outs, phase, E_RST);
            end
        end
        opcode = 3'd2;
        zero   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (outs !== E_RST || phase !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_release: got outs=%b phase=%0d, want outs=%b phase=0",
                     outs, phase, E_RST);
        end
        for (int p = 1; p <= 8; p++) begin
            step();
            vectors++;
            if (phase !== 3'(p % 8)) begin
                miscompares++;
                $display("FAIL reset_sequence step%0d: got phase=%0d, want %0d", p, phase, p % 8);
            end
        end
    endtask

    task automatic test_lda();
        logic [8:0] exp [8];
        exp = '{E_IA, E_IF, E_IL, E_ID, E_OA, 9'b010000000, 9'b010000000, 9'b010010000};
        for (int p = 0; p < 8; p++) begin
            if (p > 0) step();
            if (p < 4) begin
                opcode = 3'((p * 3 + 2) % 8);
                zero   = p[0];
                #1;
            end
            vectors++;
            if (outs !== exp[p] || phase !== 3'(p)) begin
                miscompares++;
                $display("FAIL lda phase%0d: got outs=%b phase=%0d, want outs=%b", p, outs, phase, exp[p]);
            end
            if (p == 3) begin opcode = 3'd5; zero = 1'b0; end
        end
        step();
    endtask

    task automatic test_sto();
        logic [8:0] exp [8];
        exp = '{E_IA, E_IF, E_IL, E_ID, E_OA, E_NONE, 9'b000000010, 9'b001000010};
        for (int p = 0; p < 8; p++) begin
            if (p > 0) step();
            if (p < 4) begin
                opcode = 3'((p * 5 + 1) % 8);
                zero   = ~p[0];
                #1;
            end
            vectors++;
            if (outs !== exp[p] || phase !== 3'(p)) begin
                miscompares++;
                $display("FAIL sto phase%0d: got outs=%b phase=%0d, want outs=%b", p, outs, phase, exp[p]);
            end
            if (p == 3) begin opcode = 3'd6; zero = 1'b1; end
        end
        step();
    endtask

    task automatic test_skz();
        logic [8:0] exp [8];
        for (int k = 0; k < 2; k++) begin
            // k=0: zero=1 skips (extra increment in ALU_OP); k=1: zero=0 does not.
            exp = '{E_IA, E_IF, E_IL, E_ID, E_OA, E_NONE, (k == 0) ? E_OA : E_NONE, E_NONE};
            for (int p = 0; p < 8; p++) begin
                if (p > 0) step();
                vectors++;
                if (outs !== exp[p] || phase !== 3'(p)) begin
                    miscompares++;
                    $display("FAIL skz_z%0d phase%0d: got outs=%b phase=%0d, want outs=%b",
                             1 - k, p, outs, phase, exp[p]);
                end
                if (p == 3) begin opcode = 3'd1; zero = (k == 0); end
            end
            step();
        end
    endtask

    task automatic test_jmp();
        logic [8:0] exp [8];
        exp = '{E_IA, E_IF, E_IL, E_ID, E_OA, E_NONE, 9'b000001000, 9'b000001100};
        for (int p = 0; p < 8; p++) begin
            if (p > 0) step();
            vectors++;
            if (outs !== exp[p] || phase !== 3'(p)) begin
                miscompares++;
                $display("FAIL jmp phase%0d: got outs=%b phase=%0d, want outs=%b", p, outs, phase, exp[p]);
            end
            if (p == 3) begin opcode = 3'd7; zero = 1'b1; end
        end
        step();
    endtask

    // ADD, XOR, AND back to back: all ALU ops share one strobe pattern.
    task automatic test_back_to_back();
        logic [8:0] exp [8];
        logic [2:0] ops [3];
        exp = '{E_IA, E_IF, E_IL, E_ID, E_OA, 9'b010000000, 9'b010000000, 9'b010010000};
        ops = '{3'd2, 3'd4, 3'd3};
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 8; p++) begin
                if (p > 0) step();
                vectors++;
                if (outs !== exp[p] || phase !== 3'(p)) begin
                    miscompares++;
                    $display("FAIL b2b op%0d phase%0d: got outs=%b phase=%0d, want outs=%b",
                             ops[i], p, outs, phase, exp[p]);
                end
                if (p == 3) begin opcode = ops[i]; zero = i[0]; end
            end
            step();
        end
    endtask

    // STO interrupted by reset in STORE: wr must drop without waiting for a clock.
    task automatic test_reset_mid_store();
        for (int p = 1; p < 8; p++) begin
            step();
            if (p == 3) begin opcode = 3'd6; zero = 1'b0; end
        end
        vectors++;
        if (wr !== 1'b1 || phase !== 3'd7) begin
            miscompares++;
            $display("FAIL midstore_pre: got wr=%b phase=%0d, want wr=1 phase=7", wr, phase);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (outs !== E_RST || phase !== 3'd0) begin
            miscompares++;
            $display("FAIL midstore_async: got outs=%b phase=%0d, want outs=%b phase=0",
                     outs, phase, E_RST);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (outs !== E_IF || phase !== 3'd1) begin
            miscompares++;
            $display("FAIL midstore_restart: got outs=%b phase=%0d, want outs=%b phase=1",
                     outs, phase, E_IF);
        end
        for (int p = 2; p < 8; p++) step();
        step();
    endtask

    task automatic test_hlt();
        logic [8:0] exp [5];
        exp = '{E_IA, E_IF, E_IL, E_ID, E_HLT4};
        for (int p = 0; p < 5; p++) begin
            if (p > 0) step();
            vectors++;
            if (outs !== exp[p] || phase !== 3'(p)) begin
                miscompares++;
                $display("FAIL hlt phase%0d: got outs=%b phase=%0d, want outs=%b", p, outs, phase, exp[p]);
            end
            if (p == 3) begin opcode = 3'd0; zero = 1'b0; end
        end
        for (int c = 0; c < 20; c++) begin
            step();
            opcode = 3'(c % 8);
            zero   = c[0];
            #1;
            vectors++;
            if (outs !== E_HALT || phase !== 3'd4) begin
                miscompares++;
                $display("FAIL halted cyc%0d: got outs=%b phase=%0d, want outs=%b phase=4",
                         c, outs, phase, E_HALT);
            end
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (outs !== E_RST || phase !== 3'd0) begin
            miscompares++;
            $display("FAIL halt_reset: got outs=%b phase=%0d, want outs=%b phase=0",
                     outs, phase, E_RST);
        end
        opcode = 3'd2;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (outs !== E_IF || phase !== 3'd1) begin
            miscompares++;
            $display("FAIL halt_restart: got outs=%b phase=%0d, want outs=%b phase=1",
                     outs, phase, E_IF);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sto();
        test_skz();
        test_jmp();
        test_back_to_back();
        test_reset_mid_store();
        test_hlt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
